// File: rtl/fetch_dec_pkg.sv
// Shared select encodings, the NOP bubble word and the instruction field slicer
// used by the rysyCore fetch/decode front end.
package fetch_dec_pkg;

  typedef enum logic [1:0] {
    PC_SEL_JUMP = 2'b00,
    PC_SEL_INC  = 2'b01,
    PC_SEL_HOLD = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    INST_SEL_FETCH  = 2'b00,
    INST_SEL_NOP    = 2'b01,
    INST_SEL_REPLAY = 2'b10
  } inst_sel_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } inst_fields_t;

  // Takes inst[31:2]; the two quadrant bits carry no field.
  function automatic inst_fields_t slice_fields(input logic [31:2] w);
    inst_fields_t f;
    f.opcode = w[6:2];
    f.func3  = w[14:12];
    f.func7  = w[31:25];
    f.rs1    = w[19:15];
    f.rs2    = w[24:20];
    f.rd     = w[11:7];
    return f;
  endfunction

endpackage

// File: rtl/fetch_dec_pc_reg.sv
// Program counter, next-PC mux, misaligned-target pulse and instruction-memory
// address generation.
module pc_reg
  import fetch_dec_pkg::*;
#(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter int unsigned          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic [XLEN-1:0]    target,
  output logic [XLEN-1:0]    pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               misalign
);

  logic [XLEN-1:0] pc_next;
  logic            unused_target_lsb;

  assign unused_target_lsb = target[0];

  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_SEL_JUMP: pc_next = {target[XLEN-1:2], 2'b00};
      PC_SEL_INC:  pc_next = pc + XLEN'(4);
      default:     ;
    endcase
  end

  // Addressing the ROM with the next PC lines its registered data up with pc.
  assign imem_addr = pc_next[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_next;
      misalign <= (pc_sel == PC_SEL_JUMP) && target[1];
    end
  end

endmodule

// File: rtl/fetch_dec.sv
// rysyCore front end: owns the PC, selects fetched/bubble/replayed instruction
// and splits it into decode fields; counts retired instructions.
module fetch_dec
  import fetch_dec_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     IMEM_AW  = 10,
  parameter logic [31:0]     NOP_INST = NOP_WORD,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic [1:0]         inst_sel,
  input  logic [XLEN-1:0]    target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst,
  output logic [4:0]         opcode,
  output logic [2:0]         func3,
  output logic [6:0]         func7,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [XLEN-1:0]    pc,
  output logic               illegal,
  output logic               misalign,
  output logic [CNT_W-1:0]   instret
);

  logic         boot;
  logic [31:0]  held;
  logic         bubble;
  inst_fields_t fields;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .IMEM_AW  (IMEM_AW)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .pc_sel    (pc_sel),
    .target    (target),
    .pc        (pc),
    .imem_addr (imem_addr),
    .misalign  (misalign)
  );

  // ROM output is not valid until one edge after reset release.
  always_comb begin
    inst = NOP_INST;
    if (!boot) begin
      case (inst_sel)
        INST_SEL_FETCH:  inst = imem_rdata;
        INST_SEL_REPLAY: inst = held;
        default:         ;
      endcase
    end
  end

  assign bubble  = boot | inst_sel[0];
  assign illegal = ~bubble & (inst[1:0] != 2'b11);

  assign fields = slice_fields(inst[31:2]);
  assign opcode = fields.opcode;
  assign func3  = fields.func3;
  assign func7  = fields.func7;
  assign rs1    = fields.rs1;
  assign rs2    = fields.rs2;
  assign rd     = fields.rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boot    <= 1'b1;
      held    <= NOP_INST;
      instret <= '0;
    end else begin
      boot <= 1'b0;
      held <= inst;
      if (!bubble) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: doc/fetch_dec.md
Name: fetch_dec

Overview:
- Front-end stage of the rysyCore pipeline.
- Owns the program counter and drives the instruction-memory address.
- Selects among the fetched word, a NOP bubble, or a replay of the held instruction, then splits the result into the fields consumed by ctrl, reg_file and imm_mux.
- Acts on ctrl's pc_sel/inst_sel each cycle, so ctrl's opcode/func3/func7 inputs come directly from this block.

Parameters:
- XLEN, 32: datapath and PC width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_AW, 10: instruction-memory word-address width.
- NOP_INST, 32'h0000_0013: bubble encoding (addi x0,x0,0).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_sel  in  2  from ctrl: 00 jump target, 01 pc+4, 10 hold, 11 hold.
- inst_sel  in  2  from ctrl: 00 fetched word, 01 NOP bubble, 10 replay held instruction, 11 NOP bubble.
- target  in  XLEN  jump/branch target from alu.
- imem_addr  out  IMEM_AW  word address to synchronous instruction ROM.
- imem_rdata  in  32  ROM data, valid one cycle after address.
- inst  out  32  selected instruction; goes to imm_mux.
- opcode  out  5  inst[6:2].
- func3  out  3  inst[14:12].
- func7  out  7  inst[31:25].
- rs1, rs2, rd  out  5 each  inst[19:15], inst[24:20], inst[11:7].
- pc  out  XLEN  address of the instruction currently on inst.
- illegal  out  1  inst[1:0] != 2'b11 while inst is not a bubble.
- misalign  out  1  one-cycle pulse when an accepted target has bit1 set.
- instret  out  CNT_W  count of non-bubble instructions issued.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, held instruction register=NOP_INST, instret=0.
  - boot flag=1, misalign=0.
  - With boot=1, inst shows NOP_INST, so opcode=5'b00100, func3=0, func7=0, illegal=0.
- PC next (combinational):
  - pc_sel 00: {target[XLEN-1:2],2'b00}.
  - pc_sel 01: pc+4, wrapping modulo 2^XLEN.
  - pc_sel 1x: pc.
  - pc loads the next value every rising edge when rst=1.
- imem_addr = pc_next[IMEM_AW+1:2]. This is the combinational next PC, so with 1-cycle ROM latency, imem_rdata always corresponds to the current pc register.
- Boot flag: cleared on the first rising edge after reset release. While set, inst is forced to NOP_INST regardless of inst_sel, because the ROM output is not yet valid.
- Instruction select (combinational, boot=0):
  - 00: imem_rdata.
  - 01/11: NOP_INST.
  - 10: the held register.
- Held register: loads the selected inst every edge, so replay (10) repeats the last issued word indefinitely.
- Field outputs are pure slices of inst, with zero added latency from the select.
- bubble = boot | inst_sel[0]. Replay (10) is not a bubble.
- illegal = ~bubble & (inst[1:0] != 2'b11). It is combinational and does not block the PC.
- misalign: registered. Set for exactly one cycle after an edge where pc_sel=00 and target[1]=1; bit0 is silently dropped.
- instret: +1 on each edge where bubble=0. It wraps to 0 at 2^CNT_W-1. An increment coinciding with reset assertion is lost; reset wins.
- Simultaneous pc_sel=00 with inst_sel=01 is the normal taken-branch flush: PC jumps and the current slot is a bubble.
- Reset mid-operation discards the held instruction and any pending misalign pulse.

Decomposition:
- Shared package (alongside opcodes.sv/select_pkg.sv) holds:
  - PC_SEL_* constants: 2'b00/01/10.
  - INST_SEL_* constants: 2'b00/01/10.
  - The NOP_INST constant.
  - A field-slice function returning a struct {opcode,func3,func7,rs1,rs2,rd}.
- One natural sub-module: pc_reg, holding the PC register, next-PC mux, misalign pulse and imem_addr generation. fetch_dec instantiates it and adds instruction select, boot flag, held register and instret.

Test Plan:
- Reset with rst=0 for 2 cycles, then release, ROM word0=32'h00500093:
  - During reset: pc=0, inst=32'h13, instret=0.
  - First cycle after release: inst still NOP.
  - Next cycle: inst=32'h00500093, opcode=5'b00100, rd=1.
- pc_sel=01 for 4 cycles, inst_sel=00:
  - pc steps 0,4,8,C; imem_addr steps 1,2,3,4.
  - instret increments once per cycle.
- pc_sel=00, target=32'h0000_0042, inst_sel=01:
  - Next pc=32'h40, misalign=1 for one cycle.
  - inst=NOP this cycle; instret unchanged.
- inst_sel=10 for 3 cycles with pc_sel=10 after fetching 32'h40A00133:
  - inst stays 32'h40A00133, func7=7'b0100000, func3=0.
  - pc constant; instret +3.
- ROM returns 32'hFFFFFFFC with inst_sel=00: illegal=1. With inst_sel=01: illegal=0.
- Preset instret to 2^CNT_W-1 via CNT_W=4 build, then issue one instruction: instret=0. Assert rst asynchronously mid-cycle: pc=RESET_PC immediately, without waiting for a clock edge.
